vga_stream_gen: RTL

- Source of the 23-bit VGA stream consumed by every drawing stage: free-running horizontal/vertical timing generator.
- Emits pixel coordinates, HS, VS and active-video flag, packed in the team's stream layout, one pixel per px_clk.
- Sits at the head of the video pipeline, upstream of all overlay/glyph stages; default timing is SVGA 800x600@56 Hz (36 MHz pixel clock).

---
 rtl/vga_stream_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vga_stream_gen.sv
// Free-running VGA timing generator producing the 23-bit pixel stream (XC, YC, HS, VS, Active).
// Optional macro VGA_STREAM_FRAME_CNT_EN adds the sof pulse and 8-bit frame counter outputs.

package vga_stream_pkg;

    localparam int unsigned COORD_W = 10;

    typedef struct packed {
        logic [COORD_W-1:0] xc;
        logic [COORD_W-1:0] yc;
        logic               hs;
        logic               vs;
        logic               active;
    } vga_px_t;

endpackage

module vga_stream_gen
    import vga_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 72,
    parameter int unsigned H_BP     = 128,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 22,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [22:0] strVGA
`ifdef VGA_STREAM_FRAME_CNT_EN
    ,
    output logic        sof,
    output logic [7:0]  frame
`endif
);

    localparam int unsigned CMP_W   = COORD_W + 1;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

    localparam logic [CMP_W-1:0] H_ACT_END  = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] V_ACT_END  = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] HS_START   = CMP_W'(H_ACTIVE + H_FP);
    localparam logic [CMP_W-1:0] HS_END     = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CMP_W-1:0] VS_START   = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CMP_W-1:0] VS_END     = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

    // Counters are COORD_W bits wide, so a total beyond 1024 cannot be represented.
    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("vga_stream_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("vga_stream_gen: V_TOTAL exceeds 1024");
    end
    if (H_TOTAL == 0 || V_TOTAL == 0) begin : g_zero_total_chk
        $error("vga_stream_gen: timing totals must be non-zero");
    end

    localparam vga_px_t PX_RESET = '{
        xc:     '0,
        yc:     '0,
        hs:     ~HS_POL,
        vs:     ~VS_POL,
        active: 1'b0
    };

    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic [CMP_W-1:0]   x_cmp;
    logic [CMP_W-1:0]   y_cmp;
    vga_px_t            px_q;
    vga_px_t            px_nxt;

    // Next raster position: x wraps at end of line and carries into y.
    always_comb begin
        x_nxt = x_q + COORD_W'(1);
        y_nxt = y_q;
        if (x_q == X_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
        end
    end

    // Stream fields decoded from the current (pre-increment) position.
    always_comb begin
        x_cmp         = {1'b0, x_q};
        y_cmp         = {1'b0, y_q};
        px_nxt        = PX_RESET;
        px_nxt.xc     = x_q;
        px_nxt.yc     = y_q;
        px_nxt.active = (x_cmp < H_ACT_END) && (y_cmp < V_ACT_END);
        px_nxt.hs     = ((x_cmp >= HS_START) && (x_cmp < HS_END)) ? HS_POL : ~HS_POL;
        px_nxt.vs     = ((y_cmp >= VS_START) && (y_cmp < VS_END)) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            px_q <= PX_RESET;
        end else if (en) begin
            x_q  <= x_nxt;
            y_q  <= y_nxt;
            px_q <= px_nxt;
        end
    end

    assign strVGA = px_q;

`ifdef VGA_STREAM_FRAME_CNT_EN
    logic run_q;
    logic wrap_c;

    // run_q masks the (0,0) seen right after reset, so only true frame wraps count.
    assign wrap_c = run_q && (x_q == '0) && (y_q == '0);

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            sof   <= 1'b0;
            frame <= '0;
        end else if (en) begin
            run_q <= 1'b1;
            sof   <= wrap_c;
            if (wrap_c) begin
                frame <= frame + 8'd1;
            end
        end
    end
`endif

endmodule
